mem_arbiter: RTL and testbench

- Shares the single-port unified memory between two requesters: the multi-cycle core (port c_) and a debug/program-loader port (port d_).
- Sits between the requesters and the memory instance. It owns mem_we, mem_addr and mem_wd.
- Handles one transaction at a time. Arbitration is round-robin, with a bounded lock so the core can issue back-to-back accesses.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port unified memory: round-robin between
// the core (c_) and the debug/loader port (d_), with a bounded core lock.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 1) : 3'd1;
  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);

  state_t            state_q, state_d;
  logic              owner_d;    // current transaction belongs to the debug port
  logic              rd_q;       // current transaction is a read
  logic              rr_prio_d;  // a tie goes to the debug port
  logic              lock_q;     // last grant was a core grant with c_lock set
  logic [3:0]        hold_cnt;
  logic [2:0]        wait_cnt;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic              lock_ovr, pick_c, pick_d, fwd;

  always_comb begin
    state_d  = state_q;
    pick_c   = 1'b0;
    pick_d   = 1'b0;
    lock_ovr = lock_q && c_req && (hold_cnt < HOLD_MAX);
    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          state_d = ISSUE;
          pick_c  = c_req && (!d_req || lock_ovr || !rr_prio_d);
          pick_d  = d_req && !pick_c;
        end
      end
      ISSUE: begin
        if (!rd_q)                state_d = IDLE;
        else if (RD_LATENCY > 1)  state_d = WAIT;
        else                      state_d = RESP;
      end
      WAIT:    if (wait_cnt == 3'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      c_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      c_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
      owner_d   <= 1'b0;
      rd_q      <= 1'b0;
      rr_prio_d <= 1'b0;
      lock_q    <= 1'b0;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d != IDLE);
      c_gnt    <= pick_c;
      d_gnt    <= pick_d;
      mem_we   <= pick_c ? c_we : (pick_d ? d_we : 1'b0);
      c_rvalid <= (state_d == RESP) && !owner_d;
      d_rvalid <= (state_d == RESP) && owner_d;

      if (pick_c) begin
        mem_addr  <= c_addr;
        mem_wd    <= c_wdata;
        owner_d   <= 1'b0;
        rd_q      <= !c_we;
        rr_prio_d <= 1'b1;
        lock_q    <= c_lock;
        // Only grants won through the lock while debug waits use up the budget
        if (!c_lock)               hold_cnt <= '0;
        else if (lock_ovr && d_req) hold_cnt <= hold_cnt + 4'd1;
      end else if (pick_d) begin
        mem_addr  <= d_addr;
        mem_wd    <= d_wdata;
        owner_d   <= 1'b1;
        rd_q      <= !d_we;
        rr_prio_d <= 1'b0;
        lock_q    <= 1'b0;
        hold_cnt  <= '0;
      end

      if (state_q == ISSUE)     wait_cnt <= WAIT_INIT;
      else if (state_q == WAIT) wait_cnt <= wait_cnt - 3'd1;

      // Zero-latency memories are sampled in ISSUE; otherwise keep the RESP value
      if (RD_LATENCY == 0) begin
        if (state_q == ISSUE && rd_q) begin
          if (owner_d) d_rdata_q <= mem_rd;
          else         c_rdata_q <= mem_rd;
        end
      end else if (state_q == RESP) begin
        if (owner_d) d_rdata_q <= mem_rd;
        else         c_rdata_q <= mem_rd;
      end
    end
  end

  // With a clocked RAM the word only appears in RESP, so it is forwarded there
  assign fwd     = (RD_LATENCY != 0) && (state_q == RESP);
  assign c_rdata = (fwd && !owner_d) ? mem_rd : c_rdata_q;
  assign d_rdata = (fwd && owner_d)  ? mem_rd : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses RD_LATENCY=1, instance 1
// uses RD_LATENCY=3, each backed by a clocked RAM model of matching latency.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       c_req, c_we, c_lock, d_req, d_we;
  logic [1:0][31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [1:0]       c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we, busy;
  logic [1:0][31:0] c_rdata, d_rdata, mem_addr, mem_wd, mem_rd;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(g == 0 ? 1 : 3), .MAX_HOLD(4)) u_dut (
      .clk(clk), .rst(rst),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_lock(c_lock[g]), .c_addr(c_addr[g]),
      .c_wdata(c_wdata[g]), .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]), .c_rdata(c_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wd(mem_wd[g]), .mem_rd(mem_rd[g]),
      .busy(busy[g])
    );
  end

  // RAM models: address sampled at the clock edge ending ISSUE
  logic [31:0]      ram [2][256];
  logic [1:0][31:0] p0, p1, p2;
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (mem_we[s]) ram[s][mem_addr[s][7:0]] <= mem_wd[s];
      p0[s] <= ram[s][mem_addr[s][7:0]];
      p1[s] <= p0[s];
      p2[s] <= p1[s];
    end
  end
  assign mem_rd[0] = p0[0];
  assign mem_rd[1] = p2[1];

  typedef struct {
    int          inst;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
  } gexp_t;
  typedef struct {
    int          inst;
    bit          is_d;
    logic [31:0] data;
    int          due;
  } rexp_t;

  gexp_t       gq[$];
  rexp_t       rq[$];
  logic [31:0] shadow [2][256];
  int          cyc = 0;
  int          last_g [2];
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic mon_one(input int s);
    gexp_t e;
    rexp_t r;
    int    idx;
    if (c_gnt[s] && d_gnt[s]) chk("gnt_overlap", 32'd1, 32'd0);
    if (c_gnt[s] || d_gnt[s]) begin
      idx = -1;
      foreach (gq[i]) if (idx < 0 && gq[i].inst == s) idx = i;
      if (idx < 0) chk("gnt_unexp", 32'd1, 32'd0);
      else begin
        e = gq[idx];
        gq.delete(idx);
        chk("gnt_port", 32'(d_gnt[s]), 32'(e.is_d));
        chk("gnt_we", 32'(mem_we[s]), 32'(e.we));
        chk("gnt_addr", mem_addr[s], e.addr);
        chk("gnt_busy", 32'(busy[s]), 32'd1);
        if (e.we) chk("gnt_wd", mem_wd[s], e.data);
        if (e.gap != 0) chk("gnt_gap", 32'(cyc - last_g[s]), 32'(e.gap));
        if (!e.we) rq.push_back('{s, e.is_d, e.data, cyc + (s == 0 ? 1 : 3)});
      end
      last_g[s] = cyc;
    end
    foreach (rq[i]) if (rq[i].inst == s && rq[i].due > cyc) chk("busy_rd", 32'(busy[s]), 32'd1);
    if (c_rvalid[s] && d_rvalid[s]) chk("rvalid_overlap", 32'd1, 32'd0);
    if (c_rvalid[s] || d_rvalid[s]) begin
      idx = -1;
      foreach (rq[i]) if (idx < 0 && rq[i].inst == s) idx = i;
      if (idx < 0) chk("rvalid_unexp", 32'd1, 32'd0);
      else begin
        r = rq[idx];
        rq.delete(idx);
        chk("rv_port", 32'(d_rvalid[s]), 32'(r.is_d));
        chk("rv_data", r.is_d ? d_rdata[s] : c_rdata[s], r.data);
        chk("rv_cycle", 32'(cyc), 32'(r.due));
      end
    end
  endtask

  always @(negedge clk) for (int s = 0; s < 2; s++) mon_one(s);

  task automatic expect_g(input int s, input bit is_d, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input int gap);
    gexp_t e;
    e.inst = s; e.is_d = is_d; e.we = we; e.addr = a; e.gap = gap;
    if (we) begin
      shadow[s][a[7:0]] = wd;
      e.data = wd;
    end else e.data = shadow[s][a[7:0]];
    gq.push_back(e);
  endtask

  task automatic drive(input int s, input bit is_d, input bit we, input bit lk,
                       input logic [31:0] a, input logic [31:0] wd);
    bit seen = 1'b0;
    if (is_d) begin
      d_req[s] = 1'b1; d_we[s] = we; d_addr[s] = a; d_wdata[s] = wd;
    end else begin
      c_req[s] = 1'b1; c_we[s] = we; c_lock[s] = lk; c_addr[s] = a; c_wdata[s] = wd;
    end
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = is_d ? d_gnt[s] : c_gnt[s];
    end
    if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
    if (is_d) d_req[s] = 1'b0;
    else begin
      c_req[s] = 1'b0; c_lock[s] = 1'b0;
    end
  endtask

  task automatic chk_zero(input int s, input string tag);
    chk({tag, "_ctrl"}, 32'({c_gnt[s], d_gnt[s], c_rvalid[s], d_rvalid[s], mem_we[s], busy[s]}), 32'd0);
    chk({tag, "_addr"}, mem_addr[s], 32'd0);
    chk({tag, "_wd"}, mem_wd[s], 32'd0);
    chk({tag, "_crdata"}, c_rdata[s], 32'd0);
    chk({tag, "_drdata"}, d_rdata[s], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b0;
    c_req = '0; c_we = '0; c_lock = '0; d_req = '0; d_we = '0;
    c_addr = '0; c_wdata = '0; d_addr = '0; d_wdata = '0;
    last_g[0] = 0; last_g[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    // Both ports writing, no lock: C,D,C,D from reset, one grant every 2 cycles
    expect_g(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    expect_g(0, 1'b1, 1'b1, 32'h20, 32'hB0B00020, 2);
    expect_g(0, 1'b0, 1'b1, 32'h14, 32'hC0C00014, 2);
    expect_g(0, 1'b1, 1'b1, 32'h24, 32'hB0B00024, 2);
    fork
      begin
        drive(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        drive(0, 1'b0, 1'b1, 1'b0, 32'h14, 32'hC0C00014);
      end
      begin
        drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hB0B00020);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h24, 32'hB0B00024);
      end
    join
    repeat (3) @(negedge clk);

    // Locked core vs waiting debug: 5 core grants, debug, core resumes
    for (int i = 0; i < 5; i++)
      expect_g(0, 1'b0, 1'b1, 32'h80 + 32'(4 * i), 32'hC0000000 + 32'(i), i == 0 ? 0 : 2);
    expect_g(0, 1'b1, 1'b1, 32'hA0, 32'hD00000A0, 2);
    expect_g(0, 1'b0, 1'b1, 32'h94, 32'hC0000005, 2);
    expect_g(0, 1'b0, 1'b1, 32'h98, 32'hC0000006, 2);
    expect_g(0, 1'b1, 1'b1, 32'hA4, 32'hD00000A4, 2);
    fork
      begin
        for (int i = 0; i < 7; i++)
          drive(0, 1'b0, 1'b1, 1'b1, 32'h80 + 32'(4 * i), 32'hC0000000 + 32'(i));
      end
      begin
        drive(0, 1'b1, 1'b1, 1'b0, 32'hA0, 32'hD00000A0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'hA4, 32'hD00000A4);
      end
    join
    repeat (3) @(negedge clk);

    // Core read, latency 1
    expect_g(0, 1'b0, 1'b0, 32'h10, 32'h0, 0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    expect_g(0, 1'b1, 1'b0, 32'h8C, 32'h0, 0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h8C, 32'h0);
    repeat (3) @(negedge clk);

    // Debug request raised during the ISSUE cycle of a core write
    expect_g(0, 1'b0, 1'b1, 32'h30, 32'h00003030, 0);
    expect_g(0, 1'b1, 1'b1, 32'h34, 32'h00003434, 2);
    fork
      drive(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'h00003030);
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = c_gnt[0];
        end
        if (!seen) chk("late_req_timeout", 32'd0, 32'd1);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h34, 32'h00003434);
      end
    join
    repeat (3) @(negedge clk);

    // Latency-3 instance: debug write then read
    expect_g(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 0);
    expect_g(1, 1'b1, 1'b0, 32'h40, 32'h0, 2);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h12345678);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    repeat (5) @(negedge clk);

    // Reset during WAIT of a core read: read is dropped
    expect_g(1, 1'b0, 1'b0, 32'h40, 32'h0, 0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    rq.delete();
    #1;
    chk_zero(1, "rst_wait");
    @(negedge clk) rst = 1'b1;
    repeat (6) @(negedge clk);
    expect_g(1, 1'b0, 1'b0, 32'h40, 32'h0, 0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    repeat (5) @(negedge clk);

    chk("gq_left", 32'(gq.size()), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
